// File: rtl/minirisc_mc_sequencer.sv
// Multi-cycle control sequencer for the miniRISC core: IDLE/FETCH/DECODE/EXEC/MEM/WB
// with a req/ready memory handshake, wait timeout, halt/illegal traps and a retire counter.
module minirisc_mc_sequencer #(
    parameter int OPW  = 6,
    parameter int FNW  = 5,
    parameter int TOW  = 4,
    parameter int CNTW = 16
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            run_i,
    input  logic [OPW-1:0]  opcode_i,
    input  logic [FNW-1:0]  func_i,
    input  logic            br_taken_i,
    input  logic            alu_done_i,
    input  logic            mem_ready_i,
    output logic            mem_req_o,
    output logic            mem_we_o,
    output logic            mem_sel_o,
    output logic            ir_we_o,
    output logic            alu_start_o,
    output logic            rf_we_o,
    output logic            pc_we_o,
    output logic [1:0]      pc_src_o,
    output logic            halted_o,
    output logic            err_o,
    output logic [1:0]      err_code_o,
    output logic [CNTW-1:0] retired_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_ERR
    } state_e;

    typedef enum logic [2:0] {
        C_RALU, C_IALU, C_LOAD, C_STORE, C_BRANCH, C_JUMP, C_HALT, C_ILL
    } cls_e;

    localparam logic [TOW-1:0] WAIT_LAST = TOW'((1 << TOW) - 2);

    state_e          state_q;
    cls_e            cls_q;
    cls_e            cls_dec;
    logic            multi_q;
    logic [TOW-1:0]  wait_q;
    logic [CNTW-1:0] retired_q, retired_d;
    logic            mem_req_q, mem_we_q, mem_sel_q, alu_start_q;
    logic            halted_q, err_q;
    logic [1:0]      err_code_q;
    logic            unused_func;

    assign unused_func = ^func_i[FNW-2:0];

    function automatic cls_e decode_op(input logic [OPW-1:0] op);
        if (op == {OPW{1'b1}}) return C_HALT;
        if (op > OPW'(5))      return C_ILL;
        return cls_e'(op[2:0]);
    endfunction

    assign cls_dec = decode_op(opcode_i);

    // Event pulses respond in the same cycle as ready/branch; reset suppresses them.
    always_comb begin
        ir_we_o  = 1'b0;
        rf_we_o  = 1'b0;
        pc_we_o  = 1'b0;
        pc_src_o = 2'b00;
        if (!rst_i) begin
            case (state_q)
                S_FETCH: ir_we_o = mem_ready_i;
                S_EXEC: begin
                    if (cls_q == C_BRANCH) begin
                        pc_we_o  = 1'b1;
                        pc_src_o = br_taken_i ? 2'b01 : 2'b00;
                    end else if (cls_q == C_JUMP) begin
                        pc_we_o  = 1'b1;
                        pc_src_o = 2'b10;
                    end
                end
                S_MEM:   pc_we_o = (cls_q == C_STORE) && mem_ready_i;
                S_WB: begin
                    rf_we_o = 1'b1;
                    pc_we_o = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign retired_d = (pc_we_o && retired_q != {CNTW{1'b1}}) ? retired_q + CNTW'(1) : retired_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            cls_q       <= C_RALU;
            multi_q     <= 1'b0;
            wait_q      <= '0;
            retired_q   <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_sel_q   <= 1'b0;
            alu_start_q <= 1'b0;
            halted_q    <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= 2'b00;
        end else begin
            alu_start_q <= 1'b0;
            retired_q   <= retired_d;
            case (state_q)
                S_IDLE: begin
                    if (run_i) begin
                        state_q   <= S_FETCH;
                        mem_req_q <= 1'b1;
                        mem_sel_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        wait_q    <= '0;
                    end
                end
                S_FETCH: begin
                    if (mem_ready_i) begin
                        state_q   <= S_DECODE;
                        mem_req_q <= 1'b0;
                        wait_q    <= '0;
                    end else if (wait_q == WAIT_LAST) begin
                        state_q    <= S_ERR;
                        mem_req_q  <= 1'b0;
                        err_q      <= 1'b1;
                        err_code_q <= 2'b10;
                    end else begin
                        wait_q <= wait_q + TOW'(1);
                    end
                end
                S_DECODE: begin
                    cls_q   <= cls_dec;
                    multi_q <= (cls_dec == C_RALU) && func_i[FNW-1];
                    if (cls_dec == C_HALT) begin
                        state_q  <= S_HALT;
                        halted_q <= 1'b1;
                    end else if (cls_dec == C_ILL) begin
                        state_q    <= S_ERR;
                        err_q      <= 1'b1;
                        err_code_q <= 2'b01;
                    end else begin
                        state_q     <= S_EXEC;
                        alu_start_q <= 1'b1;
                    end
                end
                S_EXEC: begin
                    case (cls_q)
                        C_RALU:  if (!multi_q || alu_done_i) state_q <= S_WB;
                        C_IALU:  state_q <= S_WB;
                        C_LOAD, C_STORE: begin
                            state_q   <= S_MEM;
                            mem_req_q <= 1'b1;
                            mem_sel_q <= 1'b1;
                            mem_we_q  <= (cls_q == C_STORE);
                            wait_q    <= '0;
                        end
                        default: begin
                            state_q   <= S_FETCH;
                            mem_req_q <= 1'b1;
                            mem_sel_q <= 1'b0;
                            mem_we_q  <= 1'b0;
                            wait_q    <= '0;
                        end
                    endcase
                end
                S_MEM: begin
                    if (mem_ready_i) begin
                        wait_q <= '0;
                        if (cls_q == C_STORE) begin
                            // Store retires here and goes straight into the next fetch request.
                            state_q   <= S_FETCH;
                            mem_req_q <= 1'b1;
                            mem_sel_q <= 1'b0;
                            mem_we_q  <= 1'b0;
                        end else begin
                            state_q   <= S_WB;
                            mem_req_q <= 1'b0;
                            mem_sel_q <= 1'b0;
                            mem_we_q  <= 1'b0;
                        end
                    end else if (wait_q == WAIT_LAST) begin
                        state_q    <= S_ERR;
                        mem_req_q  <= 1'b0;
                        mem_sel_q  <= 1'b0;
                        mem_we_q   <= 1'b0;
                        err_q      <= 1'b1;
                        err_code_q <= 2'b11;
                    end else begin
                        wait_q <= wait_q + TOW'(1);
                    end
                end
                S_WB: begin
                    state_q   <= S_FETCH;
                    mem_req_q <= 1'b1;
                    mem_sel_q <= 1'b0;
                    mem_we_q  <= 1'b0;
                    wait_q    <= '0;
                end
                default: ;
            endcase
        end
    end

    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_sel_o   = mem_sel_q;
    assign alu_start_o = alu_start_q;
    assign halted_o    = halted_q;
    assign err_o       = err_q;
    assign err_code_o  = err_code_q;
    assign retired_o   = retired_q;

endmodule

// File: tb/tb_minirisc_mc_sequencer.sv
// Randomized bench: instruction-level model expands each instruction into per-cycle
// stimulus and expected outputs, then replays them against the sequencer.
module tb_minirisc_mc_sequencer;
    localparam int OPW = 6, FNW = 5, TOW = 4, CNTW = 4;
    localparam int RMAX = (1 << CNTW) - 1;

    // Expected output vector: {req,we,sel,ir_we,alu_start,rf_we,pc_we,pc_src[1:0],halted,err,err_code[1:0]}
    localparam logic [12:0] REQ = 13'h1000, WE = 13'h0800, SEL = 13'h0400, IRW = 13'h0200,
                            AST = 13'h0100, RFW = 13'h0080, PCW = 13'h0040,
                            HLT = 13'h0008, ERR = 13'h0004;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst, run, br_taken, alu_done, mem_ready;
    logic [OPW-1:0]  opcode;
    logic [FNW-1:0]  func;
    logic            mem_req, mem_we, mem_sel, ir_we, alu_start, rf_we, pc_we, halted, err;
    logic [1:0]      pc_src, err_code;
    logic [CNTW-1:0] retired;

    minirisc_mc_sequencer #(.OPW(OPW), .FNW(FNW), .TOW(TOW), .CNTW(CNTW)) dut (
        .clk_i(clk), .rst_i(rst), .run_i(run), .opcode_i(opcode), .func_i(func),
        .br_taken_i(br_taken), .alu_done_i(alu_done), .mem_ready_i(mem_ready),
        .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_sel_o(mem_sel), .ir_we_o(ir_we),
        .alu_start_o(alu_start), .rf_we_o(rf_we), .pc_we_o(pc_we), .pc_src_o(pc_src),
        .halted_o(halted), .err_o(err), .err_code_o(err_code), .retired_o(retired)
    );

    typedef struct {
        logic           rst, run, rdy, done, br;
        logic [OPW-1:0] op;
        logic [FNW-1:0] fn;
        logic [12:0]    exp;
        int             ret;
    } cyc_t;

    cyc_t           q[$];
    logic [OPW-1:0] cur_op;
    logic [FNW-1:0] cur_fn;
    int             ret;
    int             n_chk = 0, n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic add(input logic r, input logic rdy, input logic done, input logic br,
                       input logic [12:0] e, input logic runv);
        cyc_t c;
        c.rst = r; c.run = runv; c.rdy = rdy; c.done = done; c.br = br;
        c.op = cur_op; c.fn = cur_fn; c.exp = e; c.ret = ret;
        q.push_back(c);
        if (e[6] && !r) ret = (ret == RMAX) ? RMAX : ret + 1;
    endtask

    task automatic start();
        cur_op = '0; cur_fn = '0;
        repeat ($urandom_range(1, 2)) add(0, rb(), rb(), rb(), 13'h0, 1'b0);
        add(0, rb(), rb(), rb(), 13'h0, 1'b1);
    endtask

    task automatic reset_from(input logic [12:0] e);
        add(1, rb(), rb(), rb(), e, rb());
        ret = 0;
    endtask

    task automatic absorb(input logic [12:0] e);
        repeat (4) add(0, rb(), rb(), rb(), e, rb());
    endtask

    // Memory phase: wait cycles with no ready, then ready (or timeout after 15 cycles).
    task automatic mem_phase(input int w, input logic [12:0] base, input logic [12:0] on_rdy,
                             input logic [1:0] tcode, output int stop);
        stop = 0;
        if (w >= 15) begin
            repeat (15) add(0, 0, rb(), rb(), base, rb());
            absorb(ERR | 13'(tcode));
            stop = 1;
        end else begin
            repeat (w) add(0, 0, rb(), rb(), base, rb());
            add(0, 1, rb(), rb(), base | on_rdy, rb());
        end
    endtask

    task automatic instr(input logic [OPW-1:0] op, input logic [FNW-1:0] fn, input int fw,
                         input int aw, input int mw, input logic br, output int stop);
        logic [12:0] mb;
        cur_op = op; cur_fn = fn;
        mem_phase(fw, REQ, IRW, 2'b10, stop);
        if (stop != 0) return;
        add(0, rb(), rb(), rb(), 13'h0, rb());
        if (op == 6'h3F) begin absorb(HLT); stop = 1; return; end
        if (op > 6'd5)   begin absorb(ERR | 13'h1); stop = 1; return; end
        case (op)
            6'd0, 6'd1: begin
                if (op == 6'd0 && fn[FNW-1]) begin
                    for (int k = 0; k <= aw; k++)
                        add(0, rb(), (k == aw), rb(), (k == 0) ? AST : 13'h0, rb());
                end else begin
                    add(0, rb(), rb(), rb(), AST, rb());
                end
                add(0, rb(), rb(), rb(), RFW | PCW, rb());
            end
            6'd2, 6'd3: begin
                add(0, rb(), rb(), rb(), AST, rb());
                mb = REQ | SEL | ((op == 6'd3) ? WE : 13'h0);
                mem_phase(mw, mb, (op == 6'd3) ? PCW : 13'h0, 2'b11, stop);
                if (stop != 0) return;
                if (op == 6'd2) add(0, rb(), rb(), rb(), RFW | PCW, rb());
            end
            6'd4: add(0, rb(), rb(), br, AST | PCW | (br ? 13'h10 : 13'h0), rb());
            default: add(0, rb(), rb(), rb(), AST | PCW | 13'h20, rb());
        endcase
    endtask

    initial begin
        int st;
        rst = 1; run = 0; br_taken = 0; alu_done = 0; mem_ready = 0; opcode = '0; func = '0;
        ret = 0;

        // Random program ending in HALT; retire count saturates along the way.
        start();
        for (int i = 0; i < 30; i++)
            instr(OPW'($urandom_range(0, 5)), FNW'($urandom), $urandom_range(0, 3),
                  $urandom_range(0, 7), $urandom_range(0, 4), rb(), st);
        instr(6'h3F, '0, 0, 0, 0, 0, st);
        reset_from(HLT);

        // Directed sequence from cold start, then fetch timeout.
        start();
        instr(6'd0, 5'b00000, 0, 0, 0, 0, st);
        instr(6'd2, 5'b00000, 0, 0, 3, 0, st);
        instr(6'd0, 5'b10000, 0, 6, 0, 0, st);
        instr(6'd4, 5'b00000, 0, 0, 0, 1, st);
        instr(6'd4, 5'b00000, 0, 0, 0, 0, st);
        instr(6'd5, 5'b00000, 0, 0, 0, 0, st);
        instr(6'd3, 5'b00000, 14, 0, 14, 0, st);
        instr(6'd1, 5'b00000, 15, 0, 0, 0, st);
        reset_from(ERR | 13'h2);

        start();
        instr(6'h3E, '0, 1, 0, 0, 0, st);
        reset_from(ERR | 13'h1);

        start();
        instr(6'd2, '0, 0, 0, 15, 0, st);
        reset_from(ERR | 13'h3);

        // Reset in the middle of a store handshake, with ready arriving on the reset cycle.
        start();
        instr(6'd1, '0, 0, 0, 0, 0, st);
        cur_op = 6'd3;
        add(0, 1, rb(), rb(), REQ | IRW, rb());
        add(0, rb(), rb(), rb(), 13'h0, rb());
        add(0, rb(), rb(), rb(), AST, rb());
        add(0, 0, rb(), rb(), REQ | SEL | WE, rb());
        add(1, 1, rb(), rb(), REQ | SEL | WE, rb());
        ret = 0;
        add(0, rb(), rb(), rb(), 13'h0, 1'b0);
        start();
        instr(6'd5, '0, 0, 0, 0, 0, st);
        instr(6'h3F, '0, 0, 0, 0, 0, st);

        repeat (2) @(posedge clk);
        foreach (q[i]) begin
            @(posedge clk);
            #1;
            rst = q[i].rst; run = q[i].run; mem_ready = q[i].rdy; alu_done = q[i].done;
            br_taken = q[i].br; opcode = q[i].op; func = q[i].fn;
            @(negedge clk);
            chk($sformatf("outs[%0d]", i),
                {19'h0, mem_req, mem_we, mem_sel, ir_we, alu_start, rf_we, pc_we, pc_src,
                 halted, err, err_code},
                {19'h0, q[i].exp});
            chk($sformatf("retired[%0d]", i), {28'h0, retired}, 32'(q[i].ret));
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
